// File: rtl/id_ex_alu_stage.sv
// ID/EX pipeline stage: decodes the ALU control and selects operands at accept
// time, then holds up to two decoded entries in a skid buffer toward the ALU.
module id_ex_alu_stage (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        In_Valid,
  output logic        In_Ready,
  input  logic [1:0]  ALUOp,
  input  logic [5:0]  Funct,
  input  logic        ALUSrc,
  input  logic [31:0] Rs_Data,
  input  logic [31:0] Rt_Data,
  input  logic [15:0] Imm16,
  input  logic        Flush,
  output logic        Out_Valid,
  input  logic        Out_Ready,
  output logic [31:0] A_Out,
  output logic [31:0] B_Out,
  output logic [3:0]  ALU_Ctl,
  output logic        Illegal_Op
);

  typedef enum logic [3:0] {
    CTL_AND     = 4'b0000,
    CTL_OR      = 4'b0001,
    CTL_ADD     = 4'b0010,
    CTL_SUB     = 4'b0110,
    CTL_SLT     = 4'b0111,
    CTL_NOR     = 4'b1100,
    CTL_ILLEGAL = 4'b1111
  } alu_ctl_e;

  typedef struct packed {
    alu_ctl_e    ctl;
    logic        illegal;
    logic [31:0] a;
    logic [31:0] b;
  } entry_t;

  entry_t      mem_q [2];
  entry_t      wr_entry;
  entry_t      head;
  logic        wr_ptr_q, wr_ptr_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic [1:0]  count_q, count_d;
  logic        in_ready_q;
  logic        accept;
  logic        deliver;

  // NOTE: every signal written in an always_comb gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    wr_entry         = '0;
    wr_entry.a       = Rs_Data;
    wr_entry.b       = ALUSrc ? {{16{Imm16[15]}}, Imm16} : Rt_Data;
    wr_entry.ctl     = CTL_ADD;
    wr_entry.illegal = 1'b0;
    case (ALUOp)
      2'b00: wr_entry.ctl = CTL_ADD;
      2'b01: wr_entry.ctl = CTL_SUB;
      2'b11: wr_entry.ctl = CTL_OR;
      default: begin
        case (Funct)
          6'b100000: wr_entry.ctl = CTL_ADD;
          6'b100010: wr_entry.ctl = CTL_SUB;
          6'b100100: wr_entry.ctl = CTL_AND;
          6'b100101: wr_entry.ctl = CTL_OR;
          6'b101010: wr_entry.ctl = CTL_SLT;
          6'b100111: wr_entry.ctl = CTL_NOR;
          default: begin
            wr_entry.ctl     = CTL_ILLEGAL;
            wr_entry.illegal = 1'b1;
          end
        endcase
      end
    endcase
  end

  assign Out_Valid = (count_q != 2'd0);
  assign In_Ready  = in_ready_q;
  assign accept    = In_Valid && in_ready_q;
  assign deliver   = Out_Valid && Out_Ready;

  // Flush wins over accept and deliver: the stage simply restarts empty.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (Flush) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (accept)  wr_ptr_d = ~wr_ptr_q;
      if (deliver) rd_ptr_d = ~rd_ptr_q;
      count_d = count_q + {1'b0, accept} - {1'b0, deliver};
    end
  end

  // NOTE: state registers use non-blocking assignments so all of them update from the same pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
      in_ready_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      in_ready_q <= (count_d != 2'd2);
    end
  end

  // NOTE: the entry storage has no reset; occupancy is reset instead and the outputs are gated by it.
  always_ff @(posedge clk) begin
    if (accept && !Flush) mem_q[wr_ptr_q] <= wr_entry;
  end

  assign head       = Out_Valid ? mem_q[rd_ptr_q] : '0;
  assign A_Out      = head.a;
  assign B_Out      = head.b;
  assign ALU_Ctl    = head.ctl;
  assign Illegal_Op = head.illegal;

endmodule

// File: tb/tb_id_ex_alu_stage.sv
// Bench for id_ex_alu_stage: directed vectors push hand-computed entries into a
// scoreboard; a negedge monitor pops and compares on every delivery.
module tb_id_ex_alu_stage;

  typedef struct packed {
    logic [3:0]  ctl;
    logic        ill;
    logic [31:0] a;
    logic [31:0] b;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        In_Valid, In_Ready;
  logic [1:0]  ALUOp;
  logic [5:0]  Funct;
  logic        ALUSrc;
  logic [31:0] Rs_Data, Rt_Data;
  logic [15:0] Imm16;
  logic        Flush;
  logic        Out_Valid, Out_Ready;
  logic [31:0] A_Out, B_Out;
  logic [3:0]  ALU_Ctl;
  logic        Illegal_Op;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  id_ex_alu_stage dut (
    .clk(clk), .reset_n(reset_n),
    .In_Valid(In_Valid), .In_Ready(In_Ready),
    .ALUOp(ALUOp), .Funct(Funct), .ALUSrc(ALUSrc),
    .Rs_Data(Rs_Data), .Rt_Data(Rt_Data), .Imm16(Imm16),
    .Flush(Flush),
    .Out_Valid(Out_Valid), .Out_Ready(Out_Ready),
    .A_Out(A_Out), .B_Out(B_Out), .ALU_Ctl(ALU_Ctl), .Illegal_Op(Illegal_Op)
  );

  task automatic check(input string name, input logic [68:0] got, input logic [68:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Presents one instruction and holds it until accepted; caller is at posedge+1.
  task automatic send(input logic [1:0] op, input logic [5:0] fn, input logic src,
                      input logic [31:0] rs, input logic [31:0] rt, input logic [15:0] imm,
                      input exp_t e);
    bit done = 0;
    In_Valid = 1'b1; ALUOp = op; Funct = fn; ALUSrc = src;
    Rs_Data = rs; Rt_Data = rt; Imm16 = imm;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (In_Ready) begin
        sb.push_back(e);
        done = 1;
      end
      @(posedge clk); #1;
    end
    In_Valid = 1'b0;
    check("send_accepted", {68'd0, done}, 69'd1);
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  always @(negedge clk) begin
    if (reset_n && Out_Valid && Out_Ready && !Flush) begin
      if (sb.size() == 0) begin
        check("unexpected_deliver", {ALU_Ctl, Illegal_Op, A_Out, B_Out}, 69'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("deliver", {ALU_Ctl, Illegal_Op, A_Out, B_Out}, e);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; In_Valid = 1'b0; ALUOp = 2'b00; Funct = 6'd0; ALUSrc = 1'b0;
    Rs_Data = '0; Rt_Data = '0; Imm16 = '0; Flush = 1'b0; Out_Ready = 1'b0;

    // Reset state
    #2;
    check("rst_out_valid", {68'd0, Out_Valid}, 69'd0);
    check("rst_in_ready",  {68'd0, In_Ready},  69'd0);
    check("rst_outputs",   {ALU_Ctl, Illegal_Op, A_Out, B_Out}, 69'd0);
    @(negedge clk); #1 reset_n = 1'b1;
    @(posedge clk); #1;
    check("ready_after_reset", {68'd0, In_Ready}, 69'd1);
    Out_Ready = 1'b1;

    // SLT R-type, register B operand; visible the cycle after accept
    send(2'b10, 6'b101010, 1'b0, 32'd5, 32'd9, 16'h0000, '{4'b0111, 1'b0, 32'd5, 32'd9});
    check("latency_out_valid", {68'd0, Out_Valid}, 69'd1);
    check("latency_fields", {ALU_Ctl, Illegal_Op, A_Out, B_Out}, {4'b0111, 1'b0, 32'd5, 32'd9});

    // Immediate forms with negative and positive sign extension
    send(2'b00, 6'b000000, 1'b1, 32'h100, 32'h777, 16'hFFFC, '{4'b0010, 1'b0, 32'h100, 32'hFFFF_FFFC});
    send(2'b01, 6'b000011, 1'b1, 32'h42,  32'h777, 16'h1234, '{4'b0110, 1'b0, 32'h42,  32'h0000_1234});
    send(2'b11, 6'b111111, 1'b0, 32'hA5A5_0000, 32'h0000_5A5A, 16'h8000, '{4'b0001, 1'b0, 32'hA5A5_0000, 32'h0000_5A5A});
    // Remaining R-type functions, back to back
    send(2'b10, 6'b100000, 1'b0, 32'd1, 32'd2, 16'h0, '{4'b0010, 1'b0, 32'd1, 32'd2});
    send(2'b10, 6'b100010, 1'b0, 32'd3, 32'd4, 16'h0, '{4'b0110, 1'b0, 32'd3, 32'd4});
    send(2'b10, 6'b100100, 1'b0, 32'd5, 32'd6, 16'h0, '{4'b0000, 1'b0, 32'd5, 32'd6});
    send(2'b10, 6'b100101, 1'b1, 32'd7, 32'd8, 16'h7FFF, '{4'b0001, 1'b0, 32'd7, 32'h0000_7FFF});
    send(2'b10, 6'b100111, 1'b0, 32'd9, 32'd10, 16'h0, '{4'b1100, 1'b0, 32'd9, 32'd10});
    // Illegal function, then a legal one right behind it
    send(2'b10, 6'b000011, 1'b0, 32'hDEAD, 32'hBEEF, 16'h0, '{4'b1111, 1'b1, 32'hDEAD, 32'hBEEF});
    send(2'b10, 6'b100000, 1'b0, 32'd11, 32'd12, 16'h0, '{4'b0010, 1'b0, 32'd11, 32'd12});
    cycles(3);

    // Backpressure: two accepted, third held upstream, then drained in order
    Out_Ready = 1'b0;
    send(2'b00, 6'd0, 1'b0, 32'hA1, 32'hB1, 16'h0, '{4'b0010, 1'b0, 32'hA1, 32'hB1});
    send(2'b01, 6'd0, 1'b0, 32'hA2, 32'hB2, 16'h0, '{4'b0110, 1'b0, 32'hA2, 32'hB2});
    In_Valid = 1'b1; ALUOp = 2'b11; Funct = 6'd0; ALUSrc = 1'b0; Rs_Data = 32'hA3; Rt_Data = 32'hB3;
    @(negedge clk);
    check("full_in_ready", {68'd0, In_Ready}, 69'd0);
    check("full_head", {ALU_Ctl, Illegal_Op, A_Out, B_Out}, {4'b0010, 1'b0, 32'hA1, 32'hB1});
    @(negedge clk);
    check("stall_stable", {ALU_Ctl, Illegal_Op, A_Out, B_Out}, {4'b0010, 1'b0, 32'hA1, 32'hB1});
    @(posedge clk); #1;
    Out_Ready = 1'b1;
    @(negedge clk);
    check("full_deliver_in_ready", {68'd0, In_Ready}, 69'd0);
    @(posedge clk); #1;
    check("ready_after_full_deliver", {68'd0, In_Ready}, 69'd1);
    send(2'b11, 6'd0, 1'b0, 32'hA3, 32'hB3, 16'h0, '{4'b0001, 1'b0, 32'hA3, 32'hB3});
    cycles(3);

    // Flush of a full stage with a same-cycle input and Out_Ready high
    Out_Ready = 1'b0;
    send(2'b00, 6'd0, 1'b0, 32'hC1, 32'hD1, 16'h0, '{4'b0010, 1'b0, 32'hC1, 32'hD1});
    send(2'b00, 6'd0, 1'b0, 32'hC2, 32'hD2, 16'h0, '{4'b0010, 1'b0, 32'hC2, 32'hD2});
    Flush = 1'b1; In_Valid = 1'b1; Rs_Data = 32'hC3; Rt_Data = 32'hD3; Out_Ready = 1'b1;
    @(negedge clk);
    sb.delete();
    @(posedge clk); #1;
    Flush = 1'b0; In_Valid = 1'b0;
    check("flush_out_valid", {68'd0, Out_Valid}, 69'd0);
    check("flush_in_ready",  {68'd0, In_Ready},  69'd1);
    cycles(3);
    check("flush_stays_empty", {68'd0, Out_Valid}, 69'd0);

    // Asynchronous reset between edges with an entry held
    Out_Ready = 1'b0;
    send(2'b01, 6'd0, 1'b1, 32'hE1, 32'h0, 16'h00F1, '{4'b0110, 1'b0, 32'hE1, 32'h0000_00F1});
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_out_valid", {68'd0, Out_Valid}, 69'd0);
    check("async_rst_in_ready",  {68'd0, In_Ready},  69'd0);
    check("async_rst_outputs",   {ALU_Ctl, Illegal_Op, A_Out, B_Out}, 69'd0);
    sb.delete();
    @(negedge clk); #1 reset_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_in_ready", {68'd0, In_Ready}, 69'd1);
    Out_Ready = 1'b1;
    cycles(3);
    check("post_rst_out_valid", {68'd0, Out_Valid}, 69'd0);
    send(2'b10, 6'b101010, 1'b0, 32'd20, 32'd30, 16'h0, '{4'b0111, 1'b0, 32'd20, 32'd30});

    // Drain, bounded
    for (int i = 0; i < 20 && sb.size() != 0; i++) cycles(1);
    cycles(2);
    check("scoreboard_empty", 69'(sb.size()), 69'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/id_ex_alu_stage.md
ID_EX_ALU_STAGE -- requirements
Module: id_ex_alu_stage

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 The block SHALL have the port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 The block SHALL have the port In_Valid, input, 1 bit: the upstream decode stage presents an instruction.
REQ-004 The block SHALL have the port In_Ready, output, 1 bit: the stage can accept an instruction this cycle.
REQ-005 The block SHALL have the port ALUOp, input, 2 bits: the main-control ALU operation class.
REQ-006 The block SHALL have the port Funct, input, 6 bits: the R-type function field.
REQ-007 The block SHALL have the port ALUSrc, input, 1 bit: selects the B operand (1 = immediate, 0 = Rt_Data).
REQ-008 The block SHALL have the ports Rs_Data and Rt_Data, input, 32 bits each: register-file read data.
REQ-009 The block SHALL have the port Imm16, input, 16 bits: the instruction immediate.
REQ-010 The block SHALL have the port Flush, input, 1 bit: a synchronous squash of all held entries.
REQ-011 The block SHALL have the ports Out_Valid (output, 1 bit) and Out_Ready (input, 1 bit): the handshake toward the ALU.
REQ-012 The block SHALL have the ports A_Out and B_Out, output, 32 bits each: the ALU operands.
REQ-013 The block SHALL have the port ALU_Ctl, output, 4 bits: the ALU operation code.
REQ-014 The block SHALL have the port Illegal_Op, output, 1 bit: the held entry carries an undecodable operation.

Function
REQ-015 The block SHALL accept an instruction when In_Valid and In_Ready are both 1, and SHALL deliver one when Out_Valid and Out_Ready are both 1.
REQ-016 The block SHALL store accepted instructions in a 2-entry FIFO (skid buffer) and SHALL drive In_Ready = 1 exactly when fewer than 2 entries are held.
REQ-017 The block SHALL drive In_Ready from registered state only, with no combinational path from Out_Ready.
REQ-018 Latency: an instruction accepted into an empty stage SHALL appear with Out_Valid = 1 on the next cycle.
REQ-019 The block SHALL drive Out_Valid = 1 exactly when at least 1 entry is held; outputs SHALL always show the oldest entry.
REQ-020 Outputs SHALL hold stable while Out_Valid = 1 and Out_Ready = 0.
REQ-021 On a simultaneous accept and deliver, occupancy SHALL be unchanged and order SHALL be preserved (FIFO).
REQ-022 With the stage full and Out_Ready = 1, the deliver SHALL occur and In_Ready SHALL return to 1 on the next cycle.
REQ-023 The block SHALL set A_Out = Rs_Data.
REQ-024 The block SHALL set B_Out = the sign-extended Imm16 when ALUSrc = 1, else Rt_Data; the sign extension SHALL replicate Imm16 bit 15 into bits 31:16.
REQ-025 Decode for ALUOp = 00 SHALL give ALU_Ctl = 0010 (add).
REQ-026 Decode for ALUOp = 01 SHALL give ALU_Ctl = 0110 (sub).
REQ-027 Decode for ALUOp = 11 SHALL give ALU_Ctl = 0001 (or).
REQ-028 Decode for ALUOp = 10 SHALL map Funct 100000->0010, 100010->0110, 100100->0000, 100101->0001, 101010->0111, 100111->1100.
REQ-029 Any other Funct with ALUOp = 10 SHALL give ALU_Ctl = 1111 and Illegal_Op = 1; all legal decodes SHALL give Illegal_Op = 0.
REQ-030 Decode and operand selection SHALL occur at accept time; each entry SHALL store the decoded ALU_Ctl, Illegal_Op, A and B.
REQ-031 When Flush = 1, the block SHALL empty the stage on the next edge, drop any same-cycle accept, and count no deliver in that cycle.
REQ-032 Flush SHALL take priority over all other events in the same cycle.
REQ-033 An illegal entry SHALL flow through the stage normally and SHALL NOT stall the stage.

Reset
REQ-034 While reset_n = 0, the block SHALL immediately (asynchronously) clear occupancy and the read/write pointers.
REQ-035 While reset_n = 0, the block SHALL drive Out_Valid = 0, In_Ready = 0, A_Out = 0, B_Out = 0, ALU_Ctl = 0000 and Illegal_Op = 0.
REQ-036 After reset_n deasserts, In_Ready SHALL be 1 from the first rising clk edge onward.
REQ-037 A reset asserted mid-operation SHALL discard all held entries; no partial entry SHALL be delivered afterward.

Verification
REQ-038 The bench SHALL cover: ALUOp = 10, Funct = 101010, Rs_Data = 5, Rt_Data = 9, ALUSrc = 0, Out_Ready = 1 -> next cycle Out_Valid = 1, ALU_Ctl = 0111, A_Out = 5, B_Out = 9.
REQ-039 The bench SHALL cover: ALUSrc = 1, Imm16 = 0xFFFC, ALUOp = 00 -> B_Out = 0xFFFFFFFC, ALU_Ctl = 0010.
REQ-040 The bench SHALL cover: Out_Ready = 0 with 3 back-to-back In_Valid -> 2 entries accepted, In_Ready = 0, third held upstream; then Out_Ready = 1 -> delivered in order.
REQ-041 The bench SHALL cover: ALUOp = 10, Funct = 000011 -> ALU_Ctl = 1111, Illegal_Op = 1, and the next legal instruction follows unaffected.
REQ-042 The bench SHALL cover: stage holding 2 entries, Flush = 1 with In_Valid = 1 -> next cycle Out_Valid = 0, In_Ready = 1, and no entry is delivered.
REQ-043 The bench SHALL cover: reset_n pulsed low mid-stream between clock edges -> all outputs cleared immediately, and Out_Valid = 0 until a new accept.
